// File: rtl/iram_loader_if.sv
// Signal bundle between the monitor loader and its UART byte streams,
// the instruction RAM monitor port and the CPU start controls.
interface iram_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] i_ram_wadr;
  logic [31:0] i_ram_wdata;
  logic        i_ram_wen;
  logic [11:0] i_ram_radr;
  logic [31:0] i_ram_rdata;
  logic        i_read_sel;
  logic        cpu_start;
  logic [29:0] start_adr;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, i_ram_rdata,
    output tx_data, tx_valid, i_ram_wadr, i_ram_wdata, i_ram_wen,
           i_ram_radr, i_read_sel, cpu_start, start_adr, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, i_ram_rdata,
    input  tx_data, tx_valid, i_ram_wadr, i_ram_wdata, i_ram_wen,
           i_ram_radr, i_read_sel, cpu_start, start_adr, busy
  );
endinterface

// File: rtl/iram_loader.sv
// Byte-stream command decoder that writes, reads back and launches code in
// the CPU instruction RAM ('W' write, 'R' read, 'G' go).
module iram_loader (
  input  logic          clk,
  input  logic          rst,
  iram_loader_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADR0, S_ADR1, S_CNT0, S_CNT1, S_WDAT,
    S_RADR, S_RLAT, S_RSEND, S_GADR, S_GO
  } state_e;

  state_e      state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [11:0] adr_q, adr_d;
  logic [12:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [11:0] wadr_q, wadr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [11:0] radr_q, radr_d;
  logic        read_sel_q, read_sel_d;
  logic        cpu_start_q, cpu_start_d;
  logic [29:0] start_adr_q, start_adr_d;
  logic        busy_q;

  logic [31:0] shift_word_s;
  logic [12:0] cnt_field_s;
  logic        last_word_s;

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign shift_word_s = {bus.rx_data, word_q[31:8]};
  assign cnt_field_s  = {bus.rx_data[4:0], cnt_q[7:0]};
  assign last_word_s  = (cnt_q == 13'd1);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    adr_d       = adr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    wadr_d      = wadr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    radr_d      = radr_q;
    read_sel_d  = read_sel_q;
    cpu_start_d = 1'b0;
    start_adr_d = start_adr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          idx_d = 2'd0;
          if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) begin
            state_d   = S_ADR0;
            is_read_d = (bus.rx_data == 8'h52);
          end else if (bus.rx_data == 8'h47) begin
            state_d = S_GADR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADR0: begin
        if (bus.rx_valid) begin
          adr_d[7:0] = bus.rx_data;
          state_d    = S_ADR1;
        end else begin
          state_d = S_ADR0;
        end
      end
      S_ADR1: begin
        if (bus.rx_valid) begin
          adr_d[11:8] = bus.rx_data[3:0];
          state_d     = S_CNT0;
        end else begin
          state_d = S_ADR1;
        end
      end
      S_CNT0: begin
        if (bus.rx_valid) begin
          cnt_d   = {5'd0, bus.rx_data};
          state_d = S_CNT1;
        end else begin
          state_d = S_CNT0;
        end
      end
      S_CNT1: begin
        if (bus.rx_valid) begin
          cnt_d = (cnt_field_s == 13'd0) ? 13'h1000 : cnt_field_s;
          idx_d = 2'd0;
          if (is_read_q) begin
            state_d    = S_RADR;
            read_sel_d = 1'b1;
            radr_d     = adr_q;
          end else begin
            state_d = S_WDAT;
          end
        end else begin
          state_d = S_CNT1;
        end
      end
      S_WDAT: begin
        if (bus.rx_valid) begin
          word_d = shift_word_s;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wen_d   = 1'b1;
            wadr_d  = adr_q;
            wdata_d = shift_word_s;
            adr_d   = adr_q + 12'd1;
            cnt_d   = cnt_q - 13'd1;
            state_d = last_word_s ? S_IDLE : S_WDAT;
          end else begin
            state_d = S_WDAT;
          end
        end else begin
          state_d = S_WDAT;
        end
      end
      S_RADR: begin
        state_d = S_RLAT;
      end
      S_RLAT: begin
        word_d     = bus.i_ram_rdata;
        tx_data_d  = bus.i_ram_rdata[7:0];
        tx_valid_d = 1'b1;
        idx_d      = 2'd0;
        state_d    = S_RSEND;
      end
      S_RSEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            tx_valid_d = 1'b0;
            adr_d      = adr_q + 12'd1;
            cnt_d      = cnt_q - 13'd1;
            if (last_word_s) begin
              read_sel_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              radr_d  = adr_q + 12'd1;
              state_d = S_RADR;
            end
          end else begin
            word_d    = {8'd0, word_q[31:8]};
            tx_data_d = word_q[15:8];
            state_d   = S_RSEND;
          end
        end else begin
          state_d = S_RSEND;
        end
      end
      S_GADR: begin
        if (bus.rx_valid) begin
          word_d = shift_word_s;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            start_adr_d = shift_word_s[31:2];
            cpu_start_d = 1'b1;
            state_d     = S_GO;
          end else begin
            state_d = S_GADR;
          end
        end else begin
          state_d = S_GADR;
        end
      end
      S_GO: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_read_q   <= 1'b0;
      adr_q       <= 12'd0;
      cnt_q       <= 13'd0;
      idx_q       <= 2'd0;
      word_q      <= 32'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      wadr_q      <= 12'd0;
      wdata_q     <= 32'd0;
      wen_q       <= 1'b0;
      radr_q      <= 12'd0;
      read_sel_q  <= 1'b0;
      cpu_start_q <= 1'b0;
      start_adr_q <= 30'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      adr_q       <= adr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      wadr_q      <= wadr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      radr_q      <= radr_d;
      read_sel_q  <= read_sel_d;
      cpu_start_q <= cpu_start_d;
      start_adr_q <= start_adr_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.i_ram_wadr  = wadr_q;
  assign bus.i_ram_wdata = wdata_q;
  assign bus.i_ram_wen   = wen_q;
  assign bus.i_ram_radr  = radr_q;
  assign bus.i_read_sel  = read_sel_q;
  assign bus.cpu_start   = cpu_start_q;
  assign bus.start_adr   = start_adr_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: expected RAM writes, tx bytes and CPU
// launches are queued as stimulus is sent and compared as the DUT emits them.
module tb_iram_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic toggle_mode = 1'b0;
  logic tgl_q = 1'b0;

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0;
  int tx_cnt = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  logic [43:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [29:0] go_q[$];
  logic [31:0] mem [0:4095];

  iram_loader_if bus ();

  iram_loader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Transmitter: either always ready or ready every other cycle.
  always @(posedge clk) tgl_q <= ~tgl_q;
  assign bus.tx_ready = toggle_mode ? tgl_q : 1'b1;

  // Instruction RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.i_ram_wen) mem[bus.i_ram_wadr] <= bus.i_ram_wdata;
  end
  always @(posedge clk) bus.i_ram_rdata <= mem[bus.i_ram_radr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {63'd0, bus.busy}, 64'd0);
    idle_cycles(2);
  endtask

  // Scoreboard: compare every DUT event against the head of its queue.
  always @(negedge clk) begin
    logic [43:0] ew;
    if (!rst) begin
      if (bus.i_ram_wen) begin
        wen_cnt++;
        if (wr_q.size() == 0) begin
          check("wen_unexpected", 64'd1, 64'd0);
        end else begin
          ew = wr_q.pop_front();
          check("wadr", {52'd0, bus.i_ram_wadr}, {52'd0, ew[43:32]});
          check("wdata", {32'd0, bus.i_ram_wdata}, {32'd0, ew[31:0]});
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_cnt++;
        check("read_sel_tx", {63'd0, bus.i_read_sel}, 64'd1);
        if (tx_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
        else check("tx_data", {56'd0, bus.tx_data}, {56'd0, tx_q.pop_front()});
      end
      if (bus.cpu_start) begin
        start_cnt++;
        check("go_busy", {63'd0, bus.busy}, 64'd1);
        check("go_pulse", {63'd0, prev_start}, 64'd0);
        if (go_q.size() == 0) check("go_unexpected", 64'd1, 64'd0);
        else check("start_adr", {34'd0, bus.start_adr}, {34'd0, go_q.pop_front()});
      end
      if (bus.i_ram_wen && bus.i_read_sel) check("wen_vs_sel", 64'd1, 64'd0);
      prev_start <= bus.cpu_start;
    end
  end

  initial begin
    int n;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    check("reset_outs", {bus.tx_data, bus.tx_valid, bus.i_ram_wen, bus.i_read_sel,
                         bus.cpu_start, bus.busy}, 64'd0);
    check("reset_adrs", {bus.i_ram_wadr, bus.i_ram_radr, bus.start_adr}, 64'd0);
    check("reset_wdata", {32'd0, bus.i_ram_wdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    // Two-word write at 0x010, bytes back to back.
    wr_q.push_back({12'h010, 32'h00000013});
    wr_q.push_back({12'h011, 32'h00100093});
    send(8'h57); send(8'h10); send(8'h00); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    wait_idle("w1_idle");

    // Address wrap from 0xFFF to 0x000 with upper ADR bits ignored.
    wr_q.push_back({12'hFFF, 32'h12345678});
    wr_q.push_back({12'h000, 32'hDEADBEEF});
    send(8'h57); send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); idle_cycles(2); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_idle("w2_idle");

    // Read back 0x010 with a stalling transmitter; a 'G' sent mid-read is dropped.
    tx_q.push_back(8'h13); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    tx_q.push_back(8'h93); tx_q.push_back(8'h00); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
    toggle_mode = 1'b1;
    send(8'h52); send(8'h10); send(8'h00); send(8'h02); send(8'h00);
    send(8'h47); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    wait_idle("r1_idle");
    check("read_sel_low", {63'd0, bus.i_read_sel}, 64'd0);
    toggle_mode = 1'b0;

    // Go to 0x200.
    go_q.push_back(30'h80);
    send(8'h47); send(8'h00); send(8'h02); send(8'h00); send(8'h00);
    wait_idle("g1_idle");
    check("go_pulse_end", {63'd0, bus.cpu_start}, 64'd0);

    // Unknown opcode is discarded, then go to 0x4.
    send(8'h00);
    check("bad_op_idle", {63'd0, bus.busy}, 64'd0);
    go_q.push_back(30'h1);
    send(8'h47); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    wait_idle("g2_idle");

    // Reset in the middle of a write aborts it.
    send(8'h57); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    rst = 1'b1;
    idle_cycles(2);
    check("abort_outs", {bus.tx_data, bus.tx_valid, bus.i_ram_wen, bus.i_read_sel,
                         bus.cpu_start, bus.busy}, 64'd0);
    check("abort_adrs", {bus.i_ram_wadr, bus.i_ram_radr, bus.start_adr}, 64'd0);
    check("abort_wdata", {32'd0, bus.i_ram_wdata}, 64'd0);
    rst = 1'b0;
    idle_cycles(2);
    send(8'hCC); send(8'hDD);
    check("abort_no_resume", {63'd0, bus.busy}, 64'd0);
    wr_q.push_back({12'h020, 32'h44332211});
    send(8'h57); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_idle("w3_idle");

    // One-word read with the transmitter always ready: six cycles per word.
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    send(8'h52); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    n = 0;
    while (bus.i_read_sel === 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("read_cycles", 64'(n), 64'd6);
    wait_idle("r2_idle");

    check("wen_count", 64'(wen_cnt), 64'd5);
    check("tx_count", 64'(tx_cnt), 64'd12);
    check("start_count", 64'(start_cnt), 64'd2);
    check("queues_empty", 64'(wr_q.size() + tx_q.size() + go_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
